thiele_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the Thiele CPU core: reads 32-bit instruction words

---
 rtl/thiele_pkg.sv | 20 ++
 rtl/thiele_fetch_fifo.sv | 70 +++++++
 rtl/thiele_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_thiele_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/thiele_pkg.sv
// Shared opcode constants and fetch-stage state encoding for the Thiele CPU.
package thiele_pkg;

    localparam logic [7:0] OP_PNEW    = 8'h00;
    localparam logic [7:0] OP_PSPLIT  = 8'h01;
    localparam logic [7:0] OP_PMERGE  = 8'h02;
    localparam logic [7:0] OP_LASSERT = 8'h03;
    localparam logic [7:0] OP_LJOIN   = 8'h04;
    localparam logic [7:0] OP_MDLACC  = 8'h05;
    localparam logic [7:0] OP_EMIT    = 8'h06;
    localparam logic [7:0] OP_HALT    = 8'hFF;

    typedef enum logic [1:0] {
        FS_FETCH,
        FS_WAIT,
        FS_HALTED,
        FS_ERROR
    } fetch_state_e;

endpackage

// File: rtl/thiele_fetch_fifo.sv
// Prefetch FIFO: DEPTH x W ring buffer with flush, entry count and
// a hold register so the head keeps its last popped value when empty.
module thiele_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hold_q, hold_d;
    logic          push_en;

    assign push_en = push & ~flush;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        hold_d = hold_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop) begin
                rd_d   = rd_q + 1'b1;
                hold_d = mem[rd_q];
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            hold_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    assign head_valid = (cnt_q != '0);
    assign head_data  = head_valid ? mem[rd_q] : hold_q;
    assign count      = cnt_q;

endmodule

// File: rtl/thiele_fetch_unit.sv
// Thiele instruction fetch stage: req/ack memory fetch into a prefetch FIFO.
// Define THIELE_FETCH_PARITY_EN to add mem_rpar and even-parity checking.
module thiele_fetch_unit
    import thiele_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_err,
`ifdef THIELE_FETCH_PARITY_EN
    input  logic                   mem_rpar,
`endif
    output logic                   instr_valid,
    output logic [31:0]            instr_data,
    output logic [ADDR_W-1:0]      instr_pc,
    input  logic                   instr_ready,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   halted,
    output logic                   fetch_err,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int              CW   = $clog2(DEPTH) + 1;
    localparam int              W    = 32 + ADDR_W;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] redir_pc;
    logic              ack, bus_err, push, pop;
    logic [W-1:0]      head;

`ifdef THIELE_FETCH_PARITY_EN
    assign bus_err = mem_err | (^{mem_rdata, mem_rpar});
`else
    assign bus_err = mem_err;
`endif

    assign ack      = mem_req_q & mem_ack;
    assign redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign pop      = instr_valid & instr_ready;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        drop_d     = drop_q;
        req_addr_d = req_addr_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        unique case (state_q)
            FS_FETCH: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                end else if (occupancy < FULL) begin
                    mem_req_d  = 1'b1;
                    req_addr_d = fetch_pc_q;
                    state_d    = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (ack) begin
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    state_d   = FS_FETCH;
                    // A redirect landing on the ack cycle drops this word too.
                    if (redirect_valid) begin
                        fetch_pc_d = redir_pc;
                    end else if (drop_q) begin
                        state_d = FS_FETCH;
                    end else if (bus_err) begin
                        state_d = FS_ERROR;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                        if (mem_rdata[31:24] == OP_HALT) state_d = FS_HALTED;
                    end
                end else if (redirect_valid) begin
                    drop_d     = 1'b1;
                    fetch_pc_d = redir_pc;
                end
            end
            FS_HALTED, FS_ERROR: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                    state_d    = FS_FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FS_FETCH;
            mem_req_q  <= 1'b0;
            drop_q     <= 1'b0;
            req_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            drop_q     <= drop_d;
            req_addr_q <= req_addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    thiele_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  ({mem_rdata, req_addr_q}),
        .pop        (pop),
        .head_valid (instr_valid),
        .head_data  (head),
        .count      (occupancy)
    );

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_req_q ? req_addr_q : fetch_pc_q;
    assign instr_data = head[W-1:ADDR_W];
    assign instr_pc   = head[ADDR_W-1:0];
    assign halted     = (state_q == FS_HALTED);
    assign fetch_err  = (state_q == FS_ERROR);

endmodule

// File: tb/tb_thiele_fetch_unit.sv
// Directed bench for thiele_fetch_unit with a latency-programmable memory model.
module tb_thiele_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halted;
    logic        fetch_err;
    logic [2:0]  occupancy;

    int          lat = 0;
    int          wcnt;
    bit          halt_en = 0;
    bit          err_en = 0;
    logic [31:0] halt_a = 32'h8;
    logic [31:0] err_a = 32'h10;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];
    logic [31:0] acked[$];

    always #5 clk = ~clk;

    assign mem_ack   = mem_req && (wcnt >= lat);
    assign mem_rdata = (halt_en && mem_addr == halt_a) ? 32'hFF00_0000
                                                       : 32'h0100_0005;
    assign mem_err   = err_en && (mem_addr == err_a);

    thiele_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .mem_err        (mem_err),
`ifdef THIELE_FETCH_PARITY_EN
        .mem_rpar       (^mem_rdata),
`endif
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fetch_err      (fetch_err),
        .occupancy      (occupancy)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && instr_valid && instr_ready) begin
            got_pc.push_back(instr_pc);
            got_data.push_back(instr_data);
            got_cyc.push_back(cyc);
        end
        if (rst_n && mem_req && mem_ack) acked.push_back(mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic clear_logs();
        got_pc.delete();
        got_data.delete();
        got_cyc.delete();
        acked.delete();
    endtask

    task automatic restart(input int l, input logic rdy);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        lat = l;
        instr_ready = rdy;
        @(negedge clk);
        @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        // 1: reset values, then streaming at one word per two cycles
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_data", instr_data, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_halted", halted, 0);
        check("rst_err", fetch_err, 0);
        check("rst_occ", occupancy, 0);
        restart(0, 1'b1);
        repeat (20) @(negedge clk);
        check("t1_count", got_pc.size() >= 8, 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_pc%0d", i), at(got_pc, i), 32'(i * 4));
            check($sformatf("t1_data%0d", i), at(got_data, i), 32'h0100_0005);
        end
        for (int i = 0; i < 6; i++)
            check($sformatf("t1_gap%0d", i), got_cyc[i+1] - got_cyc[i], 2);

        // 2: back-pressure saturates the FIFO
        restart(0, 1'b0);
        repeat (20) @(negedge clk);
        check("t2_occ_full", occupancy, 4);
        check("t2_req_idle", mem_req, 0);
        check("t2_req_count", acked.size(), 4);
        instr_ready = 1'b1;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 5; i++)
            check($sformatf("t2_pc%0d", i), at(got_pc, i), 32'(i * 4));
        check("t2_burst", got_cyc[3] - got_cyc[0], 3);

        // 3: HALT word stops fetch, redirect restarts it
        halt_en = 1;
        restart(0, 1'b1);
        repeat (20) @(negedge clk);
        check("t3_count", got_pc.size(), 3);
        check("t3_halt_pc", at(got_pc, 2), 32'h8);
        check("t3_halt_data", at(got_data, 2), 32'hFF00_0000);
        check("t3_halted", halted, 1);
        check("t3_no_req_c", acked.size(), 3);
        check("t3_req_idle", mem_req, 0);
        redirect(32'h40);
        check("t3_unhalt", halted, 0);
        check("t3_addr", mem_addr, 32'h40);
        got_pc.delete();
        repeat (6) @(negedge clk);
        check("t3_first_pc", at(got_pc, 0), 32'h40);
        halt_en = 0;

        // 4: redirect while a 3-cycle-latency request is outstanding
        restart(3, 1'b0);
        for (int i = 0; i < 100 && occupancy != 2; i++) @(negedge clk);
        check("t4_occ2", occupancy, 2);
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        check("t4_req3", mem_req, 1);
        check("t4_req3_addr", mem_addr, 32'h8);
        acked.delete();
        redirect(32'h103);
        check("t4_flushed", occupancy, 0);
        check("t4_req_held", mem_req, 1);
        check("t4_addr_held", mem_addr, 32'h8);
        repeat (15) @(negedge clk);
        check("t4_drop_ack", at(acked, 0), 32'h8);
        check("t4_next_req", at(acked, 1), 32'h100);
        got_pc.delete();
        instr_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_first_pc", at(got_pc, 0), 32'h100);

        // 5: bus error stops fetch until redirect
        err_en = 1;
        restart(0, 1'b1);
        repeat (20) @(negedge clk);
        check("t5_err", fetch_err, 1);
        check("t5_count", got_pc.size(), 4);
        check("t5_acks", acked.size(), 5);
        check("t5_err_addr", at(acked, 4), 32'h10);
        check("t5_req_idle", mem_req, 0);
        repeat (10) @(negedge clk);
        check("t5_no_more", acked.size(), 5);
        redirect(32'h20);
        check("t5_clear", fetch_err, 0);
        repeat (4) @(negedge clk);
        check("t5_restart", at(acked, 5), 32'h20);
        err_en = 0;

        // 6: asynchronous reset during an outstanding request
        restart(3, 1'b1);
        for (int i = 0; i < 50 && got_pc.size() < 1; i++) @(negedge clk);
        check("t6_first", got_pc.size() >= 1, 1);
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        check("t6_in_wait", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_req", mem_req, 0);
        check("t6_addr", mem_addr, 0);
        check("t6_valid", instr_valid, 0);
        check("t6_data", instr_data, 0);
        check("t6_pc", instr_pc, 0);
        check("t6_occ", occupancy, 0);
        check("t6_flags", {halted, fetch_err}, 0);
        @(negedge clk);
        @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        check("t6_req_again", mem_req, 1);
        check("t6_req_addr", mem_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
